load_store_unit: RTL and testbench

- Memory-side responder for the core's data-memory control (dmem write enable, store/load select, funct3 width).
- Takes one load/store request per instruction, checks alignment, and drives a word-aligned valid/ready data bus.
- Stalls the core until the bus transaction completes, then returns sign- or zero-extended load data.
- Sits between the execute stage (address from ALU, store data from rs2) and the data memory / bus fabric.

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store responder with alignment check and bus timeout
//
// Purpose: takes one load/store request per instruction. An illegal request
// raises misalign_err. A legal request runs a word-aligned valid/ready bus
// transfer while the core is stalled. A load returns sign- or zero-extended data.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid          core request strobe
//   store_load_sel     0 store, 1 load
//   funct3             width/sign (B, H, W, BU, HU)
//   addr, wdata        byte address, right-aligned store data
//   stall              core pipeline hold
//   rdata, rdata_valid extended load result, completion pulse
//   misalign_err       illegal request pulse
//   bus_err            bus timeout pulse
//   bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb   bus request side
//   bus_ready, bus_rdata                                bus response side
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              store_load_sel,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic          illegal;
  logic [31:0]   st_data;
  logic [3:0]    st_strb;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;

  // Reserved encodings, unsigned stores, and unaligned halves or words are rejected.
  always_comb begin
    illegal = 1'b0;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
    if (!store_load_sel && funct3[2]) illegal = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0]) illegal = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) illegal = 1'b1;
  end

  // Store data is replicated across all lanes, so the strobe alone picks the bytes.
  always_comb begin
    st_data = wdata;
    st_strb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{wdata[7:0]}};
        st_strb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data = {2{wdata[15:0]}};
        st_strb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load extraction uses the lane and width latched at request time.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  // Stall rises in the accept cycle itself so the core cannot advance past the access.
  assign stall = (state == BUS) || (state == IDLE && req_valid && !illegal);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      f3_q         <= '0;
      lane_q       <= '0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      bus_valid    <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_wstrb    <= '0;
    end else begin
      rdata_valid  <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              state        <= ERR;
              misalign_err <= 1'b1;
            end else begin
              state     <= BUS;
              bus_valid <= 1'b1;
              bus_we    <= !store_load_sel;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_wdata <= st_data;
              bus_wstrb <= store_load_sel ? 4'b0000 : st_strb;
              f3_q      <= funct3;
              lane_q    <= addr[1:0];
              cnt       <= '0;
            end
          end
        end
        BUS: begin
          // A handshake in the final timeout cycle still completes normally.
          if (bus_ready) begin
            state       <= DONE;
            bus_valid   <= 1'b0;
            rdata_valid <= 1'b1;
            if (!bus_we) rdata <= ld_data;
          end else if (cnt == CNT_LIMIT) begin
            state     <= DONE;
            bus_valid <= 1'b0;
            bus_err   <= 1'b1;
            rdata     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, bus_rdata;

  logic        rv_a, ready_a, stall_a, rvld_a, mis_a, berr_a, bv_a, bwe_a;
  logic [31:0] rdata_a, baddr_a, bwdata_a;
  logic [3:0]  bstrb_a;

  logic        rv_b, ready_b, stall_b, rvld_b, mis_b, berr_b, bv_b, bwe_b;
  logic [31:0] rdata_b, baddr_b, bwdata_b;
  logic [3:0]  bstrb_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit dut_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .store_load_sel(sel), .funct3(f3),
    .addr(addr), .wdata(wdata), .stall(stall_a), .rdata(rdata_a),
    .rdata_valid(rvld_a), .misalign_err(mis_a), .bus_err(berr_a),
    .bus_valid(bv_a), .bus_we(bwe_a), .bus_addr(baddr_a), .bus_wdata(bwdata_a),
    .bus_wstrb(bstrb_a), .bus_ready(ready_a), .bus_rdata(bus_rdata)
  );

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .store_load_sel(sel), .funct3(f3),
    .addr(addr), .wdata(wdata), .stall(stall_b), .rdata(rdata_b),
    .rdata_valid(rvld_b), .misalign_err(mis_b), .bus_err(berr_b),
    .bus_valid(bv_b), .bus_we(bwe_b), .bus_addr(baddr_b), .bus_wdata(bwdata_b),
    .bus_wstrb(bstrb_b), .bus_ready(ready_b), .bus_rdata(bus_rdata)
  );

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({stall_a, rvld_a, mis_a, berr_a, bv_a, bwe_a} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags_a: got %b want 000000", {stall_a, rvld_a, mis_a, berr_a, bv_a, bwe_a});
    end
    n_chk++;
    if ({rdata_a, baddr_a, bwdata_a, bstrb_a} !== 100'd0) begin
      n_fail++; $display("FAIL reset_data_a: got %h want 0", {rdata_a, baddr_a, bwdata_a, bstrb_a});
    end
    n_chk++;
    if ({stall_b, rvld_b, mis_b, berr_b, bv_b, bwe_b, rdata_b} !== 38'd0) begin
      n_fail++; $display("FAIL reset_b: got %h want 0", {stall_b, rvld_b, mis_b, berr_b, bv_b, bwe_b, rdata_b});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_store_byte;
    @(negedge clk);
    sel = 1'b0; f3 = 3'b000; addr = 32'h1003; wdata = 32'h0000_00A5; ready_a = 1'b1; rv_a = 1'b1;
    #1;
    n_chk++;
    if ({stall_a, bv_a} !== 2'b10) begin
      n_fail++; $display("FAIL sb_accept: stall,bus_valid got %b want 10", {stall_a, bv_a});
    end
    @(negedge clk); rv_a = 1'b0; #1;
    n_chk++;
    if ({bv_a, bwe_a, stall_a, rvld_a} !== 4'b1110) begin
      n_fail++; $display("FAIL sb_bus_flags: got %b want 1110", {bv_a, bwe_a, stall_a, rvld_a});
    end
    n_chk++;
    if (baddr_a !== 32'h1000 || bwdata_a !== 32'hA5A5_A5A5 || bstrb_a !== 4'b1000) begin
      n_fail++; $display("FAIL sb_bus_data: got %h %h %b want 00001000 a5a5a5a5 1000", baddr_a, bwdata_a, bstrb_a);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({rvld_a, stall_a, bv_a} !== 3'b100) begin
      n_fail++; $display("FAIL sb_done: rvld,stall,bv got %b want 100", {rvld_a, stall_a, bv_a});
    end
    @(negedge clk); ready_a = 1'b0; #1;
    n_chk++;
    if (rvld_a !== 1'b0) begin
      n_fail++; $display("FAIL sb_pulse_width: rdata_valid got %b want 0", rvld_a);
    end
  endtask

  task automatic test_load_half(input logic [2:0] fv, input logic [31:0] exp);
    @(negedge clk);
    sel = 1'b1; f3 = fv; addr = 32'h2002; bus_rdata = 32'h8001_1234; ready_a = 1'b1; rv_a = 1'b1;
    @(negedge clk); rv_a = 1'b0; #1;
    n_chk++;
    if ({bv_a, bwe_a, bstrb_a} !== 6'b100000 || baddr_a !== 32'h2000) begin
      n_fail++; $display("FAIL lh_bus f3=%b: got %b %h want 100000 00002000", fv, {bv_a, bwe_a, bstrb_a}, baddr_a);
    end
    @(negedge clk); #1;
    n_chk++;
    if (rvld_a !== 1'b1 || rdata_a !== exp) begin
      n_fail++; $display("FAIL lh_data f3=%b: got %b %h want 1 %h", fv, rvld_a, rdata_a, exp);
    end
    @(negedge clk); ready_a = 1'b0; bus_rdata = 32'h0; #1;
    n_chk++;
    if (rvld_a !== 1'b0 || rdata_a !== exp) begin
      n_fail++; $display("FAIL lh_hold f3=%b: got %b %h want 0 %h", fv, rvld_a, rdata_a, exp);
    end
  endtask

  task automatic test_load_byte_delayed;
    int stall_cnt;
    int bad;
    @(negedge clk);
    sel = 1'b1; f3 = 3'b000; addr = 32'h11; bus_rdata = 32'h0000_7F00; ready_a = 1'b0; rv_a = 1'b1;
    #1;
    stall_cnt = int'(stall_a);
    bad = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); rv_a = 1'b0;
      if (k == 5) ready_a = 1'b1;
      #1;
      stall_cnt += int'(stall_a);
      if (bv_a !== 1'b1 || baddr_a !== 32'h10 || bstrb_a !== 4'b0000 || bwe_a !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL lb_bus_stable: unstable cycles got %0d want 0", bad);
    end
    @(negedge clk); #1;
    n_chk++;
    if (stall_cnt != 6 || stall_a !== 1'b0) begin
      n_fail++; $display("FAIL lb_stall: cycles got %0d now %b want 6 now 0", stall_cnt, stall_a);
    end
    n_chk++;
    if (rvld_a !== 1'b1 || rdata_a !== 32'h0000_007F) begin
      n_fail++; $display("FAIL lb_data: got %b %h want 1 0000007f", rvld_a, rdata_a);
    end
    @(negedge clk); ready_a = 1'b0;
  endtask

  task automatic test_misalign(input logic s, input logic [2:0] fv, input logic [31:0] a);
    @(negedge clk);
    sel = s; f3 = fv; addr = a; wdata = 32'hFFFF; ready_a = 1'b1; rv_a = 1'b1;
    #1;
    n_chk++;
    if (stall_a !== 1'b0) begin
      n_fail++; $display("FAIL mis_stall f3=%b: got %b want 0", fv, stall_a);
    end
    @(negedge clk); rv_a = 1'b0; #1;
    n_chk++;
    if ({mis_a, bv_a, stall_a} !== 3'b100) begin
      n_fail++; $display("FAIL mis_pulse f3=%b: err,bv,stall got %b want 100", fv, {mis_a, bv_a, stall_a});
    end
    @(negedge clk); #1;
    n_chk++;
    if ({mis_a, bv_a, stall_a} !== 3'b000) begin
      n_fail++; $display("FAIL mis_end f3=%b: err,bv,stall got %b want 000", fv, {mis_a, bv_a, stall_a});
    end
    ready_a = 1'b0;
  endtask

  task automatic test_timeout;
    int vcnt;
    @(negedge clk);
    sel = 1'b1; f3 = 3'b010; addr = 32'h40; bus_rdata = 32'hDEAD_BEEF; ready_b = 1'b1; rv_b = 1'b1;
    @(negedge clk); rv_b = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (rvld_b !== 1'b1 || rdata_b !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL to_pre_load: got %b %h want 1 deadbeef", rvld_b, rdata_b);
    end
    @(negedge clk); ready_b = 1'b0; addr = 32'h44; rv_b = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); rv_b = 1'b0; #1;
      vcnt += int'(bv_b);
    end
    @(negedge clk); #1;
    n_chk++;
    if (vcnt != 4) begin
      n_fail++; $display("FAIL to_valid_cycles: got %0d want 4", vcnt);
    end
    n_chk++;
    if ({berr_b, bv_b, rvld_b, stall_b} !== 4'b1000 || rdata_b !== 32'h0) begin
      n_fail++; $display("FAIL to_abort: err,bv,rvld,stall got %b rdata %h want 1000 0", {berr_b, bv_b, rvld_b, stall_b}, rdata_b);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({berr_b, bv_b, stall_b} !== 3'b000) begin
      n_fail++; $display("FAIL to_idle: got %b want 000", {berr_b, bv_b, stall_b});
    end
    f3 = 3'b100; addr = 32'h43; ready_b = 1'b1; rv_b = 1'b1;
    @(negedge clk); rv_b = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (rvld_b !== 1'b1 || rdata_b !== 32'h0000_00DE) begin
      n_fail++; $display("FAIL to_recover: got %b %h want 1 000000de", rvld_b, rdata_b);
    end
    @(negedge clk); ready_b = 1'b0;
  endtask

  task automatic test_timeout_race;
    @(negedge clk);
    sel = 1'b1; f3 = 3'b101; addr = 32'h46; bus_rdata = 32'hBEEF_0000; ready_b = 1'b0; rv_b = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); rv_b = 1'b0;
      if (k == 4) ready_b = 1'b1;
    end
    @(negedge clk); #1;
    n_chk++;
    if ({rvld_b, berr_b} !== 2'b10 || rdata_b !== 32'h0000_BEEF) begin
      n_fail++; $display("FAIL race: rvld,err got %b rdata %h want 10 0000beef", {rvld_b, berr_b}, rdata_b);
    end
    @(negedge clk); ready_b = 1'b0;
  endtask

  task automatic test_reset_mid_bus;
    @(negedge clk);
    sel = 1'b1; f3 = 3'b010; addr = 32'h80; ready_a = 1'b0; rv_a = 1'b1;
    @(negedge clk); rv_a = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if ({stall_a, rvld_a, mis_a, berr_a, bv_a, bwe_a} !== 6'b0 || {rdata_a, baddr_a, bstrb_a} !== 68'd0) begin
      n_fail++; $display("FAIL rst_mid: flags %b data %h want 0 0", {stall_a, rvld_a, mis_a, berr_a, bv_a, bwe_a}, {rdata_a, baddr_a, bstrb_a});
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if ({rvld_a, berr_a, bv_a} !== 3'b000) begin
      n_fail++; $display("FAIL rst_no_pulse: got %b want 000", {rvld_a, berr_a, bv_a});
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    sel = 1'b0; f3 = 3'b010; addr = 32'h100; wdata = 32'h1234_5678; ready_a = 1'b1; rv_a = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if (bv_a !== 1'b1 || bwdata_a !== 32'h1234_5678 || bstrb_a !== 4'b1111) begin
      n_fail++; $display("FAIL b2b_first: got %b %h %b want 1 12345678 1111", bv_a, bwdata_a, bstrb_a);
    end
    @(negedge clk); addr = 32'h104; wdata = 32'hCAFE_F00D; #1;
    n_chk++;
    if ({rvld_a, stall_a, bv_a} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_done: rvld,stall,bv got %b want 100", {rvld_a, stall_a, bv_a});
    end
    @(negedge clk); #1;
    n_chk++;
    if ({rvld_a, stall_a, bv_a} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_accept: rvld,stall,bv got %b want 010", {rvld_a, stall_a, bv_a});
    end
    @(negedge clk); rv_a = 1'b0; #1;
    n_chk++;
    if (bv_a !== 1'b1 || baddr_a !== 32'h104 || bwdata_a !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL b2b_second: got %b %h %h want 1 00000104 cafef00d", bv_a, baddr_a, bwdata_a);
    end
    @(negedge clk); #1;
    n_chk++;
    if (rvld_a !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_done: got %b want 1", rvld_a);
    end
    @(negedge clk); ready_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; f3 = 3'b0; addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0;
    rv_a = 1'b0; ready_a = 1'b0; rv_b = 1'b0; ready_b = 1'b0;
    test_reset;
    test_store_byte;
    test_load_half(3'b001, 32'hFFFF_8001);
    test_load_half(3'b101, 32'h0000_8001);
    test_load_byte_delayed;
    test_misalign(1'b1, 3'b010, 32'h6);
    test_misalign(1'b0, 3'b100, 32'h0);
    test_timeout;
    test_timeout_race;
    test_reset_mid_bus;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
